// File: rtl/tetris_input_ctrl.sv
// PS/2 scancode stream to game-event decoder with typematic suppression,
// programmable auto-repeat for movement keys and a show-ahead event FIFO.
module tetris_input_ctrl #(
    parameter int EVENT_W       = 3,
    parameter int FIFO_DEPTH    = 8,
    parameter int REPEAT_DELAY  = 16200000,
    parameter int REPEAT_PERIOD = 5400000,
    parameter int CNT_W         = 25
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [7:0]                    ps2_key_data_i,
    input  logic                          ps2_key_data_en_i,
    input  logic                          repeat_en_i,
    input  logic                          user_event_rd_req_i,
    output logic [EVENT_W-1:0]            user_event_o,
    output logic                          user_event_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    input  logic                          clear_overflow_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [EVENT_W-1:0] EV_NONE     = {EVENT_W{1'b0}};
    localparam logic [EVENT_W-1:0] EV_LEFT     = EVENT_W'(1);
    localparam logic [EVENT_W-1:0] EV_RIGHT    = EVENT_W'(2);
    localparam logic [EVENT_W-1:0] EV_DOWN     = EVENT_W'(3);
    localparam logic [EVENT_W-1:0] EV_ROTATE   = EVENT_W'(4);
    localparam logic [EVENT_W-1:0] EV_DROP     = EVENT_W'(5);
    localparam logic [EVENT_W-1:0] EV_PAUSE    = EVENT_W'(6);
    localparam logic [EVENT_W-1:0] EV_NEW_GAME = EVENT_W'(7);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DELAY  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] CNT_PERIOD = CNT_W'(REPEAT_PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    function automatic logic [EVENT_W-1:0] map_plain(input logic [7:0] code);
        case (code)
            8'h29:   return EV_DROP;
            8'h4D:   return EV_PAUSE;
            8'h5A:   return EV_NEW_GAME;
            default: return EV_NONE;
        endcase
    endfunction

    function automatic logic [EVENT_W-1:0] map_ext(input logic [7:0] code);
        case (code)
            8'h6B:   return EV_LEFT;
            8'h74:   return EV_RIGHT;
            8'h72:   return EV_DOWN;
            8'h75:   return EV_ROTATE;
            default: return EV_NONE;
        endcase
    endfunction

    function automatic logic is_repeatable(input logic [EVENT_W-1:0] ev);
        return (ev == EV_LEFT) || (ev == EV_RIGHT) || (ev == EV_DOWN);
    endfunction

    state_t                state_r, state_nxt_s;
    logic                  make_valid_s, brk_valid_s;
    logic [EVENT_W-1:0]    make_code_s, brk_code_s;

    logic [EVENT_W-1:0]    held_r, held_nxt_s;
    logic [CNT_W-1:0]      timer_r, timer_nxt_s;
    logic                  repeat_tick_s, make_push_s, push_s;
    logic [EVENT_W-1:0]    push_data_s;

    logic [EVENT_W-1:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
    logic [LW-1:0]         level_r, level_nxt_s;
    logic                  pop_s, full_s, wr_s, ovf_set_s;
    logic [EVENT_W-1:0]    head_r, head_nxt_s;
    logic                  ready_r, overflow_r;

    // Decoder state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Decoder next state and make/break classification
    always_comb begin
        state_nxt_s  = state_r;
        make_valid_s = 1'b0;
        make_code_s  = EV_NONE;
        brk_valid_s  = 1'b0;
        brk_code_s   = EV_NONE;
        if (ps2_key_data_en_i) begin
            case (state_r)
                ST_IDLE: begin
                    if (ps2_key_data_i == 8'hE0) begin
                        state_nxt_s = ST_EXT;
                    end else if (ps2_key_data_i == 8'hF0) begin
                        state_nxt_s = ST_BRK;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                        make_code_s  = map_plain(ps2_key_data_i);
                        make_valid_s = (make_code_s != EV_NONE);
                    end
                end
                ST_EXT: begin
                    if (ps2_key_data_i == 8'hF0) begin
                        state_nxt_s = ST_EXT_BRK;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                        make_code_s  = map_ext(ps2_key_data_i);
                        make_valid_s = (make_code_s != EV_NONE);
                    end
                end
                ST_BRK: begin
                    state_nxt_s = ST_IDLE;
                    brk_valid_s = 1'b1;
                    brk_code_s  = map_plain(ps2_key_data_i);
                end
                ST_EXT_BRK: begin
                    state_nxt_s = ST_IDLE;
                    brk_valid_s = 1'b1;
                    brk_code_s  = map_ext(ps2_key_data_i);
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // A make of the already-held key is keyboard typematic and is swallowed
    assign repeat_tick_s = (held_r != EV_NONE) && repeat_en_i && (timer_r == CNT_ONE);
    assign make_push_s   = make_valid_s && (make_code_s != held_r);
    assign push_s        = make_push_s || repeat_tick_s;
    assign push_data_s   = make_push_s ? make_code_s : held_r;

    // Held key and repeat timer next state; a decoded make displaces a tick
    always_comb begin
        held_nxt_s  = held_r;
        timer_nxt_s = timer_r;
        if (make_push_s && is_repeatable(make_code_s)) begin
            held_nxt_s  = make_code_s;
            timer_nxt_s = CNT_DELAY;
        end else if (brk_valid_s && (held_r != EV_NONE) && (brk_code_s == held_r)) begin
            held_nxt_s  = EV_NONE;
            timer_nxt_s = CNT_ZERO;
        end else if (repeat_tick_s) begin
            timer_nxt_s = CNT_PERIOD;
        end else if ((held_r != EV_NONE) && repeat_en_i && (timer_r > CNT_ONE)) begin
            timer_nxt_s = timer_r - CNT_ONE;
        end else begin
            timer_nxt_s = timer_r;
        end
    end

    // Held key and repeat timer registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            held_r  <= EV_NONE;
            timer_r <= CNT_ZERO;
        end else begin
            held_r  <= held_nxt_s;
            timer_r <= timer_nxt_s;
        end
    end

    assign pop_s        = user_event_rd_req_i && (level_r != {LW{1'b0}});
    assign full_s       = (level_r == LW'(FIFO_DEPTH));
    assign wr_s         = push_s && (!full_s || pop_s);
    assign ovf_set_s    = push_s && full_s && !pop_s;
    assign rd_ptr_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;

    // FIFO level and registered head (bypasses a write landing on the new head)
    always_comb begin
        case ({wr_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
        if (wr_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = push_data_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage, pointers and status registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= EV_NONE;
            end
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= {LW{1'b0}};
            head_r     <= EV_NONE;
            ready_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            level_r  <= level_nxt_s;
            head_r   <= head_nxt_s;
            ready_r  <= (level_nxt_s != {LW{1'b0}});
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (clear_overflow_i) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign user_event_o       = head_r;
    assign user_event_ready_o = ready_r;
    assign fifo_level_o       = level_r;
    assign overflow_o         = overflow_r;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl: instance A (4-deep FIFO, slow repeat)
// covers decode/FIFO behaviour, instance B (fast repeat) covers auto-repeat timing.
module tb_tetris_input_ctrl;

    logic       clk = 1'b0;
    int         total = 0;
    int         bad = 0;

    logic       a_rst, a_en, a_rep, a_rd, a_clr;
    logic [7:0] a_data;
    logic [2:0] a_ev;
    logic       a_rdy, a_ovf;
    logic [2:0] a_lvl;

    logic       b_rst, b_en, b_rep, b_rd, b_clr;
    logic [7:0] b_data;
    logic [2:0] b_ev;
    logic       b_rdy, b_ovf;
    logic [3:0] b_lvl;

    int         rep_at [5] = '{0, 20, 30, 40, 50};
    int         exp_cnt;

    always #5 clk = ~clk;

    tetris_input_ctrl #(
        .EVENT_W(3), .FIFO_DEPTH(4), .REPEAT_DELAY(200), .REPEAT_PERIOD(100), .CNT_W(8)
    ) dut_a (
        .clk_i(clk), .rst_i(a_rst),
        .ps2_key_data_i(a_data), .ps2_key_data_en_i(a_en),
        .repeat_en_i(a_rep), .user_event_rd_req_i(a_rd),
        .user_event_o(a_ev), .user_event_ready_o(a_rdy),
        .fifo_level_o(a_lvl), .overflow_o(a_ovf),
        .clear_overflow_i(a_clr)
    );

    tetris_input_ctrl #(
        .EVENT_W(3), .FIFO_DEPTH(8), .REPEAT_DELAY(20), .REPEAT_PERIOD(10), .CNT_W(8)
    ) dut_b (
        .clk_i(clk), .rst_i(b_rst),
        .ps2_key_data_i(b_data), .ps2_key_data_en_i(b_en),
        .repeat_en_i(b_rep), .user_event_rd_req_i(b_rd),
        .user_event_o(b_ev), .user_event_ready_o(b_rdy),
        .fifo_level_o(b_lvl), .overflow_o(b_ovf),
        .clear_overflow_i(b_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        a_data = b;
        a_en   = 1'b1;
        step();
        a_en   = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        b_data = b;
        b_en   = 1'b1;
        step();
        b_en   = 1'b0;
    endtask

    task automatic pop_a();
        a_rd = 1'b1;
        step();
        a_rd = 1'b0;
    endtask

    task automatic pop_b();
        b_rd = 1'b1;
        step();
        b_rd = 1'b0;
    endtask

    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_rep = 1'b1; a_rd = 1'b0; a_clr = 1'b0; a_data = 8'h00;
        b_rst = 1'b1; b_en = 1'b0; b_rep = 1'b1; b_rd = 1'b0; b_clr = 1'b0; b_data = 8'h00;
        step(); step();
        check("rst_ready", a_rdy, 0);
        check("rst_level", a_lvl, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_event", a_ev, 0);
        a_rst = 1'b0;
        b_rst = 1'b0;
        step();

        // plain make/break, then pop
        send_a(8'h29);
        check("drop_ready", a_rdy, 1);
        check("drop_event", a_ev, 5);
        check("drop_level", a_lvl, 1);
        send_a(8'hF0);
        send_a(8'h29);
        check("drop_brk_level", a_lvl, 1);
        pop_a();
        check("pop_ready", a_rdy, 0);
        check("pop_level", a_lvl, 0);

        // typematic suppression of held extended key
        send_a(8'hE0);
        send_a(8'h6B);
        check("left_event", a_ev, 1);
        check("left_level", a_lvl, 1);
        for (int i = 0; i < 10; i++) begin
            send_a(8'hE0);
            send_a(8'h6B);
        end
        send_a(8'hE0);
        send_a(8'hF0);
        send_a(8'h6B);
        check("typematic_level", a_lvl, 1);
        check("typematic_event", a_ev, 1);
        repeat (250) step();
        check("released_no_repeat", a_lvl, 1);
        pop_a();
        check("typematic_drained", a_lvl, 0);

        // overflow on a 4-deep FIFO
        for (int i = 0; i < 9; i++) begin
            send_a(8'h29);
        end
        check("full_level", a_lvl, 4);
        check("full_ovf", a_ovf, 1);
        check("full_head", a_ev, 5);
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        check("ovf_cleared", a_ovf, 0);
        a_clr = 1'b1;
        send_a(8'h29);
        a_clr = 1'b0;
        check("ovf_beats_clear", a_ovf, 1);
        check("ovf_beats_clear_lvl", a_lvl, 4);
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        check("ovf_cleared2", a_ovf, 0);
        a_rd = 1'b1;
        send_a(8'h4D);
        a_rd = 1'b0;
        check("pushpop_full_level", a_lvl, 4);
        check("pushpop_full_ovf", a_ovf, 0);
        check("pushpop_full_head", a_ev, 5);
        pop_a();
        check("drain_lvl3", a_lvl, 3);
        pop_a();
        check("drain_lvl2", a_lvl, 2);
        check("drain_head2", a_ev, 5);
        pop_a();
        check("drain_lvl1", a_lvl, 1);
        check("drain_head_pause", a_ev, 6);
        pop_a();
        check("drain_lvl0", a_lvl, 0);
        check("drain_ready0", a_rdy, 0);

        // junk bytes, orphan break, reset mid-sequence
        send_a(8'h1C);
        send_a(8'hAA);
        send_a(8'hE0);
        send_a(8'hF0);
        send_a(8'h6B);
        check("junk_level", a_lvl, 0);
        check("junk_ready", a_rdy, 0);
        send_a(8'hE0);
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        check("midrst_level", a_lvl, 0);
        send_a(8'h5A);
        check("newgame_event", a_ev, 7);
        check("newgame_level", a_lvl, 1);

        // auto-repeat timing: make at edge 0, break completes at edge 55
        send_b(8'hE0);
        send_b(8'h74);
        for (int e = 0; e <= 70; e++) begin
            exp_cnt = 0;
            for (int k = 0; k < 5; k++) begin
                if (e >= rep_at[k]) exp_cnt++;
            end
            check($sformatf("rep_level_e%0d", e), b_lvl, exp_cnt);
            b_en = 1'b1;
            case (e)
                52:      b_data = 8'hE0;
                53:      b_data = 8'hF0;
                54:      b_data = 8'h74;
                default: b_en = 1'b0;
            endcase
            step();
        end
        b_en = 1'b0;
        check("rep_head", b_ev, 2);
        check("rep_ovf", b_ovf, 0);
        for (int i = 0; i < 5; i++) begin
            pop_b();
        end
        check("rep_drained", b_lvl, 0);
        check("rep_drained_rdy", b_rdy, 0);

        // repeat disabled: only the initial make
        b_rep = 1'b0;
        send_b(8'hE0);
        send_b(8'h74);
        for (int e = 0; e <= 60; e++) begin
            check($sformatf("norep_level_e%0d", e), b_lvl, 1);
            step();
        end
        send_b(8'hE0);
        send_b(8'hF0);
        send_b(8'h74);
        b_rep = 1'b1;
        repeat (40) step();
        check("norep_after_brk", b_lvl, 1);
        check("norep_head", b_ev, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
